// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment bus monitor: active-low segment patterns
// ({CA..CG}, 0 = segment lit), the blank pattern, and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
  localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
  localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
  localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0001100;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b1100000;
  localparam logic [6:0] SEG_HEX_C = 7'b0110001;
  localparam logic [6:0] SEG_HEX_D = 7'b1000010;
  localparam logic [6:0] SEG_HEX_E = 7'b0110000;
  localparam logic [6:0] SEG_HEX_F = 7'b0111000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern decoder: active-low {CA..CG} -> hex nibble.
// Anything outside the 16 hex glyphs (including blank) is reported as not legal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitor for a multiplexed 7-segment bus: recovers the nibble shown on each digit.
// Build option SEG7_DP_CAPTURE_EN: when defined, DP joins the stability compare and
// dp_on is captured; otherwise DP is ignored and dp_on is tied low.
//
// state  | meaning
// IDLE   | waiting for exactly one anode low
// SETTLE | sample word stable for settle_cnt cycles, not yet captured
// HOLD   | captured; waiting for the bus to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int EPOCH_CYCLES  = 200_000
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic [NUM_DIGITS-1:0]   AN,
  input  logic [6:0]              SEG,
  input  logic                    DP,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   seg_error,
  output logic [NUM_DIGITS-1:0]   dp_on,
  output logic                    update_pulse,
  output logic [2:0]              update_index
);

  localparam int SW = NUM_DIGITS + 8;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int EW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;

  logic [NUM_DIGITS-1:0] an_m, an_s;
  logic [6:0]            seg_m, seg_s;
  logic                  dp_bit;
  logic [SW-1:0]         samp, samp_prev;

  state_t                state, state_nxt;
  logic [CW-1:0]         settle_cnt, settle_cnt_nxt;
  logic                  one_low, same, capture;
  logic [2:0]            cap_idx;
  logic [NUM_DIGITS-1:0] cap_mask;
  logic                  legal;
  logic [3:0]            nibble;

  logic [EW-1:0]         epoch_cnt;
  logic [NUM_DIGITS-1:0] seen;
  logic                  wrap;

  // Synchronizers idle at all-ones: no anode strobed, all segments dark.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      an_m  <= '1;
      an_s  <= '1;
      seg_m <= '1;
      seg_s <= '1;
    end else begin
      an_m  <= AN;
      an_s  <= an_m;
      seg_m <= SEG;
      seg_s <= seg_m;
    end
  end

`ifdef SEG7_DP_CAPTURE_EN
  logic dp_m, dp_s;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      dp_m <= 1'b1;
      dp_s <= 1'b1;
    end else begin
      dp_m <= DP;
      dp_s <= dp_m;
    end
  end

  assign dp_bit = dp_s;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      dp_on <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) dp_on[i] <= ~dp_s;
      end
    end
  end
`else
  logic unused_dp;
  assign unused_dp = DP;
  assign dp_bit    = 1'b1;
  assign dp_on     = '0;
`endif

  assign samp    = {an_s, seg_s, dp_bit};
  assign one_low = $onehot(~an_s);
  assign same    = (samp == samp_prev);

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) cap_idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    capture        = 1'b0;
    case (state)
      IDLE: begin
        state_nxt      = one_low ? SETTLE : IDLE;
        settle_cnt_nxt = one_low ? CW'(1) : '0;
      end
      SETTLE: begin
        if (!same) begin
          state_nxt      = one_low ? SETTLE : IDLE;
          settle_cnt_nxt = one_low ? CW'(1) : '0;
        end else if (settle_cnt >= CW'(SETTLE_CYCLES)) begin
          capture        = 1'b1;
          state_nxt      = HOLD;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!same) begin
          state_nxt      = one_low ? SETTLE : IDLE;
          settle_cnt_nxt = one_low ? CW'(1) : '0;
        end
      end
      default: begin
        state_nxt      = IDLE;
        settle_cnt_nxt = '0;
      end
    endcase
  end

  assign cap_mask = capture ? ~an_s : '0;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state      <= IDLE;
      settle_cnt <= '0;
      samp_prev  <= '1;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      samp_prev  <= samp;
    end
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s),
    .legal   (legal),
    .nibble  (nibble)
  );

  // An illegal glyph keeps the last good nibble so the error is visible against it.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      digits       <= '0;
      seg_error    <= '0;
      update_pulse <= 1'b0;
      update_index <= '0;
    end else begin
      update_pulse <= capture;
      if (capture) update_index <= cap_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_mask[i]) begin
          if (legal) digits[4*i +: 4] <= nibble;
          seg_error[i] <= ~legal;
        end
      end
    end
  end

  assign wrap = (epoch_cnt == EW'(EPOCH_CYCLES - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      epoch_cnt   <= '0;
      seen        <= '0;
      digit_valid <= '0;
    end else if (wrap) begin
      epoch_cnt   <= '0;
      seen        <= '0;
      digit_valid <= seen | cap_mask;
    end else begin
      epoch_cnt   <= epoch_cnt + EW'(1);
      seen        <= seen | cap_mask;
      digit_valid <= digit_valid | cap_mask;
    end
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the multiplexed 7-segment bus: samples the active-low anode strobes and segment cathodes driven to the display, and recovers the hex nibble shown on each digit.
- Used as an in-fabric monitor / loopback checker for the display drivers; sits beside the display driver, tapping the same AN/CA..CG/DP nets.
- Reports per-digit value, validity (refreshed recently), and illegal-pattern error.

Parameters:
- NUM_DIGITS, 8, number of anode lines / digits tracked (1..8).
- SETTLE_CYCLES, 4, consecutive identical synchronized samples required before a capture (>=1).
- EPOCH_CYCLES, 200_000, refresh window length; a digit not captured within one window loses valid.

Ports:
- CLK100MHZ  in  1  system clock.
- CPU_RESETN  in  1  synchronous active-low reset.
- AN  in  NUM_DIGITS  anode strobes, active low.
- SEG  in  7  cathodes, active low, bit6=CA ... bit0=CG.
- DP  in  1  decimal-point cathode, active low.
- digits  out  4*NUM_DIGITS  recovered nibbles, digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  digit captured in current or previous epoch.
- seg_error  out  NUM_DIGITS  last capture for digit was not a legal hex pattern.
- dp_on  out  NUM_DIGITS  last captured DP state, 1 = lit.
- update_pulse  out  1  one-cycle strobe on every capture.
- update_index  out  3  digit index of the latest capture.

Behaviour:
- Clock CLK100MHZ; reset synchronous, active low (CPU_RESETN); all state changes on posedge.
- Reset: digits=0, digit_valid=0, seg_error=0, dp_on=0, update_pulse=0, update_index=0; FSM=IDLE; counters=0.
- Inputs AN, SEG, DP pass through a 2-flop synchronizer; all logic uses synchronized values.
- Sample word S = {AN, SEG, DP}; S_prev registered each cycle.
- FSM:
  - IDLE: if exactly one AN bit low -> SETTLE, settle_cnt=1. Zero or several low -> stay.
  - SETTLE: S==S_prev -> settle_cnt++; S!=S_prev -> back to IDLE evaluation the same cycle (restart count at 1 if one-hot-low). When settle_cnt reaches SETTLE_CYCLES -> capture, go HOLD.
  - HOLD: stay while S==S_prev; any change -> IDLE evaluation as above.
- Capture (single cycle): index i = position of low AN bit; decode SEG.
  - Legal pattern: digits[i]=nibble, seg_error[i]=0.
  - Illegal pattern (incl. blank 1111111): digits[i] unchanged, seg_error[i]=1.
  - dp_on[i]=~DP; seen[i]=1; update_pulse=1 next cycle only; update_index=i.
- Latency: pin change to update_pulse high = 2 (sync) + SETTLE_CYCLES + 1 cycles.
- One capture per strobe interval: a held digit is not recaptured until S changes.
- Epoch: counter 0..EPOCH_CYCLES-1, wraps. At wrap: digit_valid = seen | (capture this cycle), seen cleared (a same-cycle capture sets digit_valid and is not lost). Between wraps digit_valid also sets immediately on capture.
- Legal patterns, {CA..CG} active low: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0001100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
- Mid-operation reset: all of the above cleared in the reset cycle; synchronizer flops also reset (to all-ones, i.e. inactive).

Optional Feature:
- SEG7_DP_CAPTURE_EN
  - Defined: DP is part of S (stability compare), and dp_on is captured as above.
  - Undefined: DP is ignored entirely and dp_on is tied 0.

Decomposition:
- Package seg7_pkg holds:
  - the 16 active-low segment-pattern constants;
  - FSM state typedef (IDLE/SETTLE/HOLD);
  - SEG_BLANK=7'b1111111.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern -> {legal, nibble[3:0]}; shared with future display checkers.

Test Plan:
- Scan: AN=8'b1111_1110 with SEG=0000110 for 100 cycles, then AN=8'b1111_1101 with SEG=0001000 -> digits[3:0]=3, digits[7:4]=A, exactly 2 update_pulses, update_index 0 then 1, digit_valid=8'b0000_0011.
- Glitch: SEG toggles each cycle for 20 cycles on digit 0 (SETTLE_CYCLES=4) -> no update_pulse; on stabilizing at 1001111, capture of 1 after 2+4+1 cycles.
- Illegal pattern: digit 2 shows 1111111 after a previously captured 5 -> seg_error[2]=1, digits[11:8] remains 5; then 0100100 -> seg_error[2]=0.
- Two anodes low (AN=8'b1111_1100) for 1000 cycles -> no capture, outputs unchanged.
- Staleness (EPOCH_CYCLES=1000): capture digit 0, then idle the bus -> digit_valid[0] stays 1 through the first wrap, clears at the second wrap.
- Reset mid-HOLD: assert CPU_RESETN=0 for 1 cycle -> all outputs 0 on the next edge; re-capture needs the full settle latency.
